message_scroller: RTL and testbench
===================================

// Module: message_scroller
// PURPOSE
// Upstream feeder for the four-digit LED driver: holds a MSG_LEN-entry message of 4-bit character codes.
// Presents a sliding 4-character window (char3..char0) that the digit-multiplexing FSM and LED decoder display.
// Window advances one position every SCROLL_CYCLES clocks, left or right, wrapping modulo MSG_LEN.
// Message entries are rewritable at run time through a single-cycle write port.
// PARAMETERS
// SCROLL_CYCLES  50_000_000  clocks per scroll step (1 s at 50 MHz); legal range >= 2
// MSG_LEN        16          message length in characters; legal range 4..16
// CNT_W          26          tick counter width; must satisfy 2**CNT_W >= SCROLL_CYCLES
// PORTS
// clk        in   1  system clock (the board clock, not a DCM-divided clock)
// reset      in   1  synchronous, active-high reset (debounced reset from the top level)
// scroll_en  in   1  1 = scrolling runs; 0 = window frozen
// dir        in   1  0 = scroll left (ptr+1), 1 = scroll right (ptr-1)
// wr_en      in   1  write strobe, one cycle
// wr_idx     in   4  message index to write
// wr_char    in   4  character code to write
// char3      out  4  leftmost displayed character (msg[ptr])
// char2      out  4  msg[(ptr+1) mod MSG_LEN]
// char1      out  4  msg[(ptr+2) mod MSG_LEN]
// char0      out  4  msg[(ptr+3) mod MSG_LEN]
// shift_tick out  1  one-cycle pulse, high in the cycle ptr takes its new value
// BEHAVIOUR
// - One clock (clk). reset is synchronous and active-high; every register is sampled on clk rising edge.
// - On reset: cnt=0, ptr=0, msg[i]=i (i=0..MSG_LEN-1), shift_tick=0, char3..char0 = 0,1,2,3.
// - Tick counter: scroll_en=1 -> cnt increments; at cnt==SCROLL_CYCLES-1 it wraps to 0 and a step fires.
// - scroll_en=0 -> cnt cleared to 0, ptr held. First step after re-enable comes SCROLL_CYCLES clocks later.
// - Step: dir=0 -> ptr = (ptr==MSG_LEN-1) ? 0 : ptr+1; dir=1 -> ptr = (ptr==0) ? MSG_LEN-1 : ptr-1.
// - dir is sampled only in the step cycle; changing dir mid-count does not reset cnt.
// - shift_tick is a registered output: high exactly in the cycle following the step edge, i.e. with the new ptr.
// - Window index arithmetic is modulo MSG_LEN, computed with a compare-and-subtract, never a power-of-2 mask.
// - char outputs are registered from (ptr, msg): one-cycle latency after any ptr or msg change.
//   Sequence: step edge -> shift_tick=1 and new ptr -> next edge -> chars updated.
// - Write: wr_en=1 with wr_idx < MSG_LEN -> msg[wr_idx] = wr_char at the edge.
//   wr_idx >= MSG_LEN -> write ignored, no state change.
// - Simultaneous write and step: both take effect at the same edge. The next char update uses the new ptr and new content.
// - reset asserted mid-count or mid-write overrides everything; a write in the reset cycle is discarded.
// - No combinational path from inputs to outputs.
// STRUCTURE
// - Shared package: the character-code constants used by the LED decoder (CH_0..CH_F, CH_BLANK=4'hF).
//   The package also holds the default SCROLL_CYCLES.
// - Sub-module scroll_tick_gen: cnt plus enable/clear logic, emits the one-cycle step strobe.
// - Top: ptr register, msg register file (MSG_LEN x 4 flops, no RAM), window mux, output registers.
// TESTING (SCROLL_CYCLES=4, MSG_LEN=16)
// 1. Reset, scroll_en=0 for 20 clk -> chars stay 0,1,2,3; shift_tick never high.
// 2. scroll_en=1, dir=0 -> shift_tick every 4th clk. Chars step 1,2,3,4 then 2,3,4,5;
//    after 13 steps they read D,E,F,0 (wrap).
// 3. From reset, dir=1, scroll_en=1 -> after the first step ptr=15; chars read F,0,1,2.
// 4. Write wr_idx=5, wr_char=A with ptr=3 -> chars read 3,4,A,6 two clk later. Write wr_idx=16 -> no change.
// 5. Write at the same edge as a step (ptr 2->3, wr_idx=6, wr_char=0) -> next chars read 3,4,5,0.
// 6. Assert reset for 1 clk at ptr=9 mid-count with wr_en=1 ->
//    next cycle chars 0,1,2,3, msg restored to identity, first step 4 clk after release.

Source files
------------

// File: rtl/message_scroller_pkg.sv
// Shared definitions for the scroller and the downstream LED decoder:
// character codes, default scroll period and the write-request bundle.
package message_scroller_pkg;

  localparam int DEF_SCROLL_CYCLES = 50_000_000;

  localparam logic [3:0] CH_0 = 4'h0, CH_1 = 4'h1, CH_2 = 4'h2, CH_3 = 4'h3;
  localparam logic [3:0] CH_4 = 4'h4, CH_5 = 4'h5, CH_6 = 4'h6, CH_7 = 4'h7;
  localparam logic [3:0] CH_8 = 4'h8, CH_9 = 4'h9, CH_A = 4'hA, CH_B = 4'hB;
  localparam logic [3:0] CH_C = 4'hC, CH_D = 4'hD, CH_E = 4'hE, CH_F = 4'hF;
  localparam logic [3:0] CH_BLANK = 4'hF;

  typedef struct packed {
    logic       en;
    logic [3:0] idx;
    logic [3:0] chr;
  } wr_req_t;

endpackage

// File: rtl/message_scroller_tick_gen.sv
// Scroll period counter: runs while enabled, clears when disabled, and
// raises step for one cycle on the wrap edge.
module scroll_tick_gen
  import message_scroller_pkg::*;
#(
  parameter int SCROLL_CYCLES = DEF_SCROLL_CYCLES,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic scroll_en,
  output logic step
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(SCROLL_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (!scroll_en) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
      step  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/message_scroller.sv
// Message store with a registered 4-character sliding window; the window
// start pointer steps left or right once per scroll period, wrapping at MSG_LEN.
module message_scroller
  import message_scroller_pkg::*;
#(
  parameter int SCROLL_CYCLES = DEF_SCROLL_CYCLES,
  parameter int MSG_LEN       = 16,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scroll_en,
  input  logic       dir,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  logic [3:0] wr_char,
  output logic [3:0] char3,
  output logic [3:0] char2,
  output logic [3:0] char1,
  output logic [3:0] char0,
  output logic       shift_tick
);

  localparam logic [4:0] LEN  = 5'(MSG_LEN);
  localparam logic [3:0] LAST = 4'(MSG_LEN - 1);

  logic                     step;
  logic [3:0]               ptr_q, ptr_d;
  logic [MSG_LEN-1:0][3:0]  msg_q, msg_d;
  logic [3:0][3:0]          win_q, win_d;   // win[k] = msg[ptr+k], k=0 is char3
  logic                     shift_tick_q, shift_tick_d;
  wr_req_t                  wr;

  assign wr = '{en: wr_en, idx: wr_idx, chr: wr_char};

  scroll_tick_gen #(
    .SCROLL_CYCLES (SCROLL_CYCLES),
    .CNT_W         (CNT_W)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .scroll_en (scroll_en),
    .step      (step)
  );

  always_comb begin
    ptr_d        = ptr_q;
    shift_tick_d = step;
    if (step) begin
      if (!dir) ptr_d = (ptr_q == LAST) ? 4'd0 : ptr_q + 4'd1;
      else      ptr_d = (ptr_q == 4'd0) ? LAST : ptr_q - 4'd1;
    end
  end

  // Out-of-range indices are dropped so a short message never aliases.
  always_comb begin
    msg_d = msg_q;
    if (wr.en && ({1'b0, wr.idx} < LEN)) msg_d[wr.idx] = wr.chr;
  end

  for (genvar k = 0; k < 4; k++) begin : g_win
    logic [4:0] sum;
    logic [3:0] idx;
    assign sum      = {1'b0, ptr_q} + 5'(k);
    assign idx      = (sum >= LEN) ? 4'(sum - LEN) : sum[3:0];
    assign win_d[k] = msg_q[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      shift_tick_q <= 1'b0;
      win_q        <= {4'd3, 4'd2, 4'd1, 4'd0};
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= 4'(i);
    end else begin
      ptr_q        <= ptr_d;
      shift_tick_q <= shift_tick_d;
      win_q        <= win_d;
      msg_q        <= msg_d;
    end
  end

  assign char3      = win_q[0];
  assign char2      = win_q[1];
  assign char1      = win_q[2];
  assign char0      = win_q[3];
  assign shift_tick = shift_tick_q;

endmodule

// File: tb/tb_message_scroller.sv
// Directed bench for message_scroller with SCROLL_CYCLES=4: a vector table
// plus loops for the long scroll runs and a short-message instance for wrap/ignore.
module tb_message_scroller;

  logic       clk = 1'b0;
  logic       reset, scroll_en, dir, wr_en;
  logic [3:0] wr_idx, wr_char;
  logic [3:0] char3, char2, char1, char0;
  logic       shift_tick;

  logic       s_reset, s_en, s_dir, s_wr;
  logic [3:0] s_idx, s_char;
  logic [3:0] s_c3, s_c2, s_c1, s_c0;
  logic       s_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  message_scroller #(.SCROLL_CYCLES(4), .MSG_LEN(16), .CNT_W(26)) dut (
    .clk(clk), .reset(reset), .scroll_en(scroll_en), .dir(dir),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char),
    .char3(char3), .char2(char2), .char1(char1), .char0(char0),
    .shift_tick(shift_tick)
  );

  message_scroller #(.SCROLL_CYCLES(4), .MSG_LEN(12), .CNT_W(26)) dut_short (
    .clk(clk), .reset(s_reset), .scroll_en(s_en), .dir(s_dir),
    .wr_en(s_wr), .wr_idx(s_idx), .wr_char(s_char),
    .char3(s_c3), .char2(s_c2), .char1(s_c1), .char0(s_c0),
    .shift_tick(s_tick)
  );

  typedef struct {
    int         pre;     // unchecked cycles with these inputs before the checked one
    logic       rst, en, d, wr;
    logic [3:0] idx, ch;
    logic [15:0] exp_chars;
    logic       exp_tick;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int pre, logic rst, logic en, logic d, logic wr,
                              logic [3:0] idx, logic [3:0] ch,
                              logic [15:0] ec, logic et, string nm);
    vec_t v;
    v.pre = pre; v.rst = rst; v.en = en; v.d = d; v.wr = wr;
    v.idx = idx; v.ch = ch; v.exp_chars = ec; v.exp_tick = et; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic en, logic d, logic wr, logic [3:0] idx, logic [3:0] ch);
    reset = rst; scroll_en = en; dir = d; wr_en = wr; wr_idx = idx; wr_char = ch;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    s_reset = 1'b1; s_en = 1'b0; s_dir = 1'b0; s_wr = 1'b0; s_idx = 4'd0; s_char = 4'd0;

    // Test 1: reset, then frozen for 20 cycles
    cycle();
    check("reset_chars", {char3, char2, char1, char0}, 16'h0123);
    check("reset_tick", {15'd0, shift_tick}, 16'd0);
    s_reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("frozen_chars", {char3, char2, char1, char0}, 16'h0123);
      check("frozen_tick", {15'd0, shift_tick}, 16'd0);
    end

    // Test 2: scroll left 13 steps, tick on every 4th edge
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int e = 1; e <= 53; e++) begin
      cycle();
      check("left_tick", {15'd0, shift_tick}, {15'd0, (e % 4) == 0});
      if (e == 5)  check("left_step1", {char3, char2, char1, char0}, 16'h1234);
      if (e == 9)  check("left_step2", {char3, char2, char1, char0}, 16'h2345);
      if (e == 53) check("left_wrap",  {char3, char2, char1, char0}, 16'hDEF0);
    end

    // Test 3: scroll right from reset
    add(0, 1, 0, 0, 0, 0, 0, 16'h0123, 0, "r_reset");
    add(0, 0, 1, 1, 0, 0, 0, 16'h0123, 0, "r_cnt1");
    add(0, 0, 1, 1, 0, 0, 0, 16'h0123, 0, "r_cnt2");
    add(0, 0, 1, 1, 0, 0, 0, 16'h0123, 0, "r_cnt3");
    add(0, 0, 1, 1, 0, 0, 0, 16'h0123, 1, "r_step");
    add(0, 0, 1, 1, 0, 0, 0, 16'hF012, 0, "r_chars");
    // Test 5: write coinciding with step 2->3
    add(0, 1, 0, 0, 0, 0, 0, 16'h0123, 0, "s_reset");
    add(2, 0, 1, 0, 0, 0, 0, 16'h0123, 0, "s_cnt3");
    add(0, 0, 1, 0, 0, 0, 0, 16'h0123, 1, "s_step1");
    add(2, 0, 1, 0, 0, 0, 0, 16'h1234, 0, "s_hold1");
    add(0, 0, 1, 0, 0, 0, 0, 16'h1234, 1, "s_step2");
    add(2, 0, 1, 0, 0, 0, 0, 16'h2345, 0, "s_hold2");
    add(0, 0, 1, 0, 1, 4'd6, 4'd0, 16'h2345, 1, "wr_step");
    add(0, 0, 1, 0, 0, 0, 0, 16'h3450, 0, "wr_step_chars");
    // Test 6: reset at ptr=9 mid-count with a write in the reset cycle
    add(23, 0, 1, 0, 0, 0, 0, 16'h9ABC, 0, "ptr9_chars");
    add(0, 0, 1, 0, 0, 0, 0, 16'h9ABC, 0, "ptr9_cnt2");
    add(0, 1, 1, 0, 1, 4'd0, 4'd7, 16'h0123, 0, "mid_reset");
    add(0, 0, 1, 0, 0, 0, 0, 16'h0123, 0, "post_rst1");
    add(1, 0, 1, 0, 0, 0, 0, 16'h0123, 0, "post_rst3");
    add(0, 0, 1, 0, 0, 0, 0, 16'h0123, 1, "post_rst_step");
    add(0, 0, 1, 0, 0, 0, 0, 16'h1234, 0, "post_rst_chars");
    // Test 4: write msg[5] while frozen at ptr=3, then re-enable
    add(6, 0, 1, 0, 0, 0, 0, 16'h2345, 1, "to_ptr3");
    add(0, 0, 0, 0, 0, 0, 0, 16'h3456, 0, "ptr3_chars");
    add(0, 0, 0, 0, 1, 4'd5, 4'hA, 16'h3456, 0, "wr5_edge");
    add(0, 0, 0, 0, 0, 0, 0, 16'h34A6, 0, "wr5_chars");
    add(3, 0, 0, 0, 0, 0, 0, 16'h34A6, 0, "frozen_hold");
    add(2, 0, 1, 0, 0, 0, 0, 16'h34A6, 0, "reen_cnt3");
    add(0, 0, 1, 0, 0, 0, 0, 16'h34A6, 1, "reen_step");
    add(0, 0, 1, 0, 0, 0, 0, 16'h4A67, 0, "reen_chars");

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].wr, vecs[i].idx, vecs[i].ch);
      for (int p = 0; p < vecs[i].pre; p++) cycle();
      cycle();
      check({vecs[i].name, "_chars"}, {char3, char2, char1, char0}, vecs[i].exp_chars);
      check({vecs[i].name, "_tick"}, {15'd0, shift_tick}, {15'd0, vecs[i].exp_tick});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Short message: out-of-range writes ignored, right wrap lands on index 11
    s_wr = 1'b1; s_idx = 4'd12; s_char = 4'h9; cycle();
    s_idx = 4'd15; cycle();
    s_idx = 4'd11; s_char = 4'h5; cycle();
    s_wr = 1'b0; cycle();
    check("short_ignore", {s_c3, s_c2, s_c1, s_c0}, 16'h0123);
    s_en = 1'b1; s_dir = 1'b1;
    for (int e = 1; e <= 4; e++) cycle();
    check("short_step_tick", {15'd0, s_tick}, 16'd1);
    cycle();
    check("short_wrap", {s_c3, s_c2, s_c1, s_c0}, 16'h5012);
    s_en = 1'b0; s_dir = 1'b0;
    cycle();
    check("short_right_hold", {s_c3, s_c2, s_c1, s_c0}, 16'h5012);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
